// File: rtl/axi_mem_arb.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ valid/ready requesters.
// Each requester owns a response slot with a holding register, so a stalled response never blocks the SRAM.

// Protocol properties of the arbiter, kept apart from the datapath.
module axi_mem_arb_chk #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            grant,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic                          sram_cs,
  input  logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  input  logic [NUM_REQ-1:0]            rsp_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata
);
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_cs_has_req:   assert property (@(posedge clk) disable iff (rst) sram_cs |-> (|req_valid));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp_stable
    a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
      (rsp_valid[g] && !rsp_ready[g]) |=>
        (rsp_valid[g] && $stable(rsp_we[g]) && $stable(rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH])));
  end
endmodule

module axi_mem_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ-1:0]            rsp_we,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata,
  output logic                          sram_cs,
  output logic                          sram_we,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_wdata,
  input  logic [DATA_WIDTH-1:0]         sram_rdata
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    elig_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  found_s;
  logic [PTR_W-1:0]      rr_next_s;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [NUM_REQ-1:0]    rsp_we_r;
  logic [NUM_REQ-1:0]    fresh_r;
  logic [DATA_WIDTH-1:0] hold_r [NUM_REQ];

  // Round-robin grant: pass 0 scans rr_ptr..NUM_REQ-1, pass 1 wraps to 0..rr_ptr-1.
  always_comb begin
    logic hit;
    elig_s    = req_valid & (~rsp_valid_r | rsp_ready);
    grant_s   = '0;
    found_s   = 1'b0;
    rr_next_s = rr_ptr_r;
    hit       = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit        = !found_s && elig_s[i] && ((p == 0) == (i >= int'(rr_ptr_r)));
        grant_s[i] = grant_s[i] | hit;
        rr_next_s  = hit ? ((i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1)) : rr_next_s;
        found_s    = found_s | hit;
      end
    end
  end

  // AND-OR mux of the granted request onto the SRAM port; all zero when nothing is granted.
  always_comb begin
    sram_cs    = found_s;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sram_we    = sram_we | (grant_s[i] & req_we[i]);
      sram_addr  = sram_addr  | ({ADDR_WIDTH{grant_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sram_wdata = sram_wdata | ({DATA_WIDTH{grant_s[i]}} & req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Read data comes straight from the SRAM in the first response cycle, from the hold register after.
  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{rsp_valid_r[i] & ~rsp_we_r[i]}} &
                                              (fresh_r[i] ? sram_rdata : hold_r[i]);
    end
  end

  // Pointer and response-slot state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      rsp_valid_r <= '0;
      rsp_we_r    <= '0;
      fresh_r     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        hold_r[i] <= '0;
      end
    end else begin
      if (found_s) begin
        rr_ptr_r <= rr_next_s;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_s[i]) begin
          rsp_valid_r[i] <= 1'b1;
          rsp_we_r[i]    <= req_we[i];
          fresh_r[i]     <= 1'b1;
        end else if (rsp_valid_r[i] && rsp_ready[i]) begin
          rsp_valid_r[i] <= 1'b0;
          rsp_we_r[i]    <= 1'b0;
          fresh_r[i]     <= 1'b0;
        end else if (fresh_r[i]) begin
          // Stalled in its first cycle: park the SRAM data before the port is reused.
          hold_r[i]  <= sram_rdata;
          fresh_r[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_we    = rsp_we_r;

  axi_mem_arb_chk #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .grant     (grant_s),
    .req_valid (req_valid),
    .sram_cs   (sram_cs),
    .rsp_valid (rsp_valid_r),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we_r),
    .rsp_rdata (rsp_rdata)
  );
endmodule

// File: tb/tb_axi_mem_arb.sv
// Scoreboard bench for axi_mem_arb: directed scenarios followed by randomized traffic on four requesters,
// checked against a reference memory and a round-robin grant model.
module tb_axi_mem_arb;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rsp_rdata;
  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_q [N][$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  axi_mem_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    case (a)
      16:      return 32'hDEADBEEF;
      4:       return 32'h12345678;
      default: return 32'(a) * 32'h9E3779B1 + 32'h1;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM model: one-cycle read latency, writes land at the clock edge.
  initial begin : sram_model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    for (int a = 0; a < (1 << AW); a++) mem[a] = init_val(a);
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        else         sram_rdata     <= mem[sram_addr];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Reference model: expected grant, SRAM drive and response for every accepted request.
  initial begin : tracker
    int            rr, g, idx;
    int            wait_c [N];
    logic [N-1:0]  elig, eg;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    exp_t          e;
    for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(a);
    rr = 0;
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) begin
          exp_q[i].delete();
          wait_c[i] = 0;
        end
        rr = 0;
      end else begin
        for (int i = 0; i < N; i++)
          elig[i] = req_valid[i] && (exp_q[i].size() == 0 || rsp_ready[i]);
        g = -1;
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (g < 0 && elig[idx]) g = idx;
        end
        eg = '0; e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (g >= 0) begin
          eg[g]  = 1'b1;
          e_cs   = 1'b1;
          e_we   = req_we[g];
          e_addr = req_addr[g*AW +: AW];
          e_wd   = req_wdata[g*DW +: DW];
        end
        check("grant", 64'(req_ready), 64'(eg));
        check("sram_drive", {14'd0, sram_cs, sram_we, sram_addr, sram_wdata}, {14'd0, e_cs, e_we, e_addr, e_wd});
        for (int i = 0; i < N; i++) begin
          if (req_ready[i]) begin
            check($sformatf("starve[%0d]", i), 64'(wait_c[i] <= N - 1), 64'd1);
            wait_c[i] = 0;
          end else if (elig[i]) wait_c[i]++;
          else wait_c[i] = 0;
        end
        if (g >= 0) begin
          e.we   = e_we;
          e.data = e_we ? '0 : ref_mem[e_addr];
          e.cyc  = cyc;
          if (e_we) ref_mem[e_addr] = e_wd;
          exp_q[g].push_back(e);
          rr = (g + 1) % N;
        end
      end
    end
  end

  // Monitor: every presented response is compared against the oldest expected entry.
  initial begin : monitor
    logic have_old;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          have_old = (exp_q[i].size() > 0) && (exp_q[i][0].cyc < cyc);
          if (rsp_valid[i]) begin
            if (!have_old) begin
              n_cmp++; n_fail++;
              $display("FAIL rsp_unexpected[%0d]: got rsp_valid=1, expected no response (t=%0t)", i, $time);
            end else begin
              check($sformatf("rsp_we[%0d]", i), 64'(rsp_we[i]), 64'(exp_q[i][0].we));
              check($sformatf("rsp_data[%0d]", i), 64'(rsp_rdata[i*DW +: DW]), 64'(exp_q[i][0].data));
              if (rsp_ready[i]) void'(exp_q[i].pop_front());
            end
          end else if (have_old) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_missing[%0d]: got rsp_valid=0, expected 1 (t=%0t)", i, $time);
            void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({rsp_valid, rsp_we, req_ready, sram_cs, |rsp_rdata}), 64'd0);
    rst = 1'b0;
    rsp_ready = '1;
    tick();

    // Single read
    set_req(0, 1'b0, 16'h0010, 32'h0);
    tick();
    check("t1_valid", 64'(rsp_valid[0]), 64'd1);
    check("t1_rdata", 64'(rsp_rdata[31:0]), 64'hDEADBEEF);
    tick();
    check("t1_done", 64'(rsp_valid), 64'd0);

    // Contention from rr_ptr=0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (!req_valid[0]) set_req(0, 1'b0, 16'(16'h0100 + k), 32'h0);
      if (!req_valid[1]) set_req(1, 1'b0, 16'(16'h0180 + k), 32'h0);
      #1;
      check("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("t2_cs", 64'(sram_cs), 64'd1);
      tick();
    end
    req_valid = '0;
    repeat (2) tick();

    // Back-pressure on requester 1 while requester 0 keeps the SRAM busy
    do_reset();
    rsp_ready = 4'b1101;
    set_req(1, 1'b0, 16'h0004, 32'h0);
    tick();
    set_req(1, 1'b0, 16'h0008, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (!req_valid[0]) set_req(0, 1'b0, 16'(16'h0200 + k), 32'h0);
      #1;
      check("t3_hold", 64'(rsp_rdata[63:32]), 64'h12345678);
      check("t3_valid", 64'(rsp_valid[1]), 64'd1);
      check("t3_block", 64'(req_ready[1]), 64'd0);
      tick();
    end
    req_valid[0] = 1'b0;
    rsp_ready = '1;
    #1;
    check("t3_regrant", 64'(req_ready[1]), 64'd1);
    tick();
    check("t3_next", 64'(rsp_rdata[63:32]), 64'(init_val(8)));
    repeat (2) tick();

    // Write then read
    do_reset();
    set_req(0, 1'b1, 16'h0020, 32'hA5A5A5A5);
    tick();
    check("t4_ack", 64'({rsp_valid[0], rsp_we[0]}), 64'd3);
    check("t4_ack_data", 64'(rsp_rdata[31:0]), 64'd0);
    set_req(0, 1'b0, 16'h0020, 32'h0);
    tick();
    check("t4_rd_we", 64'(rsp_we[0]), 64'd0);
    check("t4_rd_data", 64'(rsp_rdata[31:0]), 64'hA5A5A5A5);
    tick();

    // Reset in the cycle after a grant
    do_reset();
    set_req(1, 1'b0, 16'h0030, 32'h0);
    tick();
    check("t5_pre", 64'(rsp_valid[1]), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rsp_clr", 64'(rsp_valid), 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t5_quiet", 64'(rsp_valid), 64'd0);
    set_req(1, 1'b0, 16'h0031, 32'h0);
    set_req(2, 1'b0, 16'h0032, 32'h0);
    #1;
    check("t5_rr", 64'(req_ready), 64'd2);
    repeat (3) tick();

    // Random traffic
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), $urandom());
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();
    for (int i = 0; i < N; i++)
      check($sformatf("drain[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
